dual_fetch_queue: RTL

Upstream neighbour of the dual-issue unit. It fetches aligned 64-bit instruction pairs from the I-cache and buffers them in a circular word queue. Each cycle it presents the two oldest words as instr1/instr2. It advances by 2 words per cycle normally, or by 1 word when the issue stage asserts rollback. A branch redirect flushes the queue and restarts fetch at a new PC.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/word_ring_buffer.sv | 83 ++++++++
 rtl/dual_fetch_queue.sv | 109 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-side types and constants for the
// dual fetch queue and its word ring buffer.
package fetch_pkg;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] BUBBLE = '0;
  localparam logic [31:0] PAIR_BYTES = 32'd8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } fetch_state_e;
endpackage

// File: rtl/word_ring_buffer.sv
// Circular DEPTH x 32 word store with a 2-word write
// port (optional low-word skip), 0/1/2 pop and flush.
module word_ring_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic                   wr_skip,
  input  logic [2*INSTR_W-1:0]   wr_data,
  input  logic [1:0]             pop_n,
  output logic [INSTR_W-1:0]     rd0,
  output logic [INSTR_W-1:0]     rd1,
  output logic [1:0]             rd_vld,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [INSTR_W-1:0] mem_d [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW-1:0] head1, tail1;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] push_n;

  always_comb begin
    head1 = head_q + AW'(1);
    tail1 = tail_q + AW'(1);
    push_n = '0;
    if (wr_en) push_n = wr_skip ? CW'(1) : CW'(2);
    mem_d = mem_q;
    head_d = head_q + AW'(pop_n);
    tail_d = tail_q + AW'(push_n);
    count_d = count_q + push_n - CW'(pop_n);
    if (wr_en) begin
      if (wr_skip) begin
        mem_d[tail_q] = wr_data[63:32];
      end else begin
        mem_d[tail_q] = wr_data[31:0];
        mem_d[tail1] = wr_data[63:32];
      end
    end
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= BUBBLE;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      mem_q <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end

  // slots beyond the live count read as bubbles
  always_comb begin
    rd0 = (count_q != '0) ? mem_q[head_q] : BUBBLE;
    rd1 = (count_q > CW'(1)) ? mem_q[head1] : BUBBLE;
    rd_vld = {count_q > CW'(1), count_q != '0};
  end

  assign count = count_q;

  ovf_a: assert property (
    @(posedge clk) disable iff (!rst_n)
    count_d <= CW'(DEPTH)
  );
endmodule

// File: rtl/dual_fetch_queue.sv
// Fetches aligned instruction pairs from the I-cache
// into a word ring and presents the two oldest words.
module dual_fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               ic_req,
  output logic [31:0]        ic_addr,
  input  logic               ic_valid,
  input  logic [63:0]        ic_data,
  output logic [INSTR_W-1:0] instr1,
  output logic [INSTR_W-1:0] instr2,
  output logic [1:0]         pair_valid,
  input  logic               issue_adv,
  input  logic               rollback,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc
);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] addr_q, addr_d;
  logic        req_q, req_d;
  logic        skip_q, skip_d;
  logic        enq_go, can_req, room;
  logic [1:0]  pop_n, enq_n;
  logic [CW-1:0] count;
  logic [CW:0]   used;

  always_comb begin
    enq_go = ic_valid && (state_q == WAIT);
    enq_n = '0;
    if (enq_go) enq_n = skip_q ? 2'd1 : 2'd2;
    pop_n = '0;
    if (issue_adv && count != '0)
      pop_n = (rollback || count == CW'(1)) ? 2'd1 : 2'd2;
    // a request reserves a pair after this cycle's traffic
    used = (CW+1)'(count) + (CW+1)'(enq_n) - (CW+1)'(pop_n);
    room = used <= (CW+1)'(DEPTH - 2);

    state_d = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d = addr_q;
    skip_d = skip_q;
    req_d = 1'b0;
    can_req = 1'b0;
    unique case (state_q)
      IDLE: can_req = 1'b1;
      WAIT: if (ic_valid) begin
        state_d = IDLE;
        skip_d = 1'b0;
        can_req = 1'b1;
      end
      DROP: if (ic_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (can_req && room) begin
      req_d = 1'b1;
      addr_d = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + PAIR_BYTES;
      state_d = WAIT;
    end
    if (redirect) begin
      req_d = 1'b0;
      addr_d = addr_q;
      fetch_pc_d = {redirect_pc[31:3], 3'b000};
      skip_d = redirect_pc[2];
      state_d = (state_q != IDLE && !ic_valid) ? DROP : IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q <= RESET_PC;
      req_q <= 1'b0;
      skip_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q <= addr_d;
      req_q <= req_d;
      skip_q <= skip_d;
    end
  end

  assign ic_req = req_q;
  assign ic_addr = addr_q;

  word_ring_buffer #(.DEPTH(DEPTH)) u_ring (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (redirect),
    .wr_en   (enq_go),
    .wr_skip (skip_q),
    .wr_data (ic_data),
    .pop_n   (pop_n),
    .rd0     (instr1),
    .rd1     (instr2),
    .rd_vld  (pair_valid),
    .count   (count)
  );
endmodule
